// File: rtl/peripheral_dac_seq.sv
// Bus-mapped sequencer for a 4-channel parallel DAC: latches four codes, then pulses LDAC.
module peripheral_dac_seq #(
    parameter int unsigned DW     = 8,
    parameter int unsigned T_SU   = 2,
    parameter int unsigned T_WR   = 4,
    parameter int unsigned T_HOLD = 2,
    parameter int unsigned T_LD   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   d_in,
    input  logic          cs,
    input  logic [3:0]    addr,
    input  logic          rd,
    input  logic          wr,
    output logic [15:0]   d_out,
    output logic [DW-1:0] dac_data,
    output logic [1:0]    dac_addr,
    output logic          dac_wr_n,
    output logic          dac_ldac_n
);

    localparam int unsigned M_A   = (T_SU > T_WR) ? T_SU : T_WR;
    localparam int unsigned M_B   = (T_HOLD > T_LD) ? T_HOLD : T_LD;
    localparam int unsigned T_MAX = (M_A > M_B) ? M_A : M_B;
    localparam int unsigned CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_LOAD
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   ch_q  [4];
    logic [DW-1:0]   ch_d  [4];
    logic [DW-1:0]   buf_q [4];
    logic [DW-1:0]   buf_d [4];
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [15:0]     d_out_q, d_out_d;
    logic [DW-1:0]   dac_data_q, dac_data_d;
    logic [1:0]      dac_addr_q, dac_addr_d;
    logic            wr_n_q, wr_n_d;
    logic            ldac_n_q, ldac_n_d;

    logic            wr_ok;
    logic            rd_ok;
    logic            start;
    logic            unused_d_in;

    assign wr_ok       = cs & wr & ~rd;
    assign rd_ok       = cs & rd & ~wr;
    assign start       = wr_ok && (addr == 4'hA) && d_in[0] && !busy_q;
    assign unused_d_in = ^d_in[15:DW];

    // State and output registers; strobes return inactive asynchronously on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                ch_q[i]  <= '0;
                buf_q[i] <= '0;
            end
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            d_out_q    <= '0;
            dac_data_q <= '0;
            dac_addr_q <= '0;
            wr_n_q     <= 1'b1;
            ldac_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            buf_q      <= buf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            d_out_q    <= d_out_d;
            dac_data_q <= dac_data_d;
            dac_addr_q <= dac_addr_d;
            wr_n_q     <= wr_n_d;
            ldac_n_q   <= ldac_n_d;
        end
    end

    // Bus decode, register writes and the per-channel write/load sequencer
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        buf_d      = buf_q;
        busy_d     = busy_q;
        done_d     = done_q;
        d_out_d    = '0;
        dac_data_d = dac_data_q;
        dac_addr_d = dac_addr_q;
        wr_n_d     = wr_n_q;
        ldac_n_d   = ldac_n_q;

        if (rd_ok) begin
            case (addr)
                4'h0, 4'h2, 4'h4, 4'h6: d_out_d = 16'(ch_q[addr[2:1]]);
                4'h8:                   d_out_d = {14'b0, done_q, busy_q};
                default:                d_out_d = '0;
            endcase
        end

        if (wr_ok) begin
            case (addr)
                4'h0, 4'h2, 4'h4, 4'h6: ch_d[addr[2:1]] = d_in[DW-1:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    buf_d      = ch_q;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    state_d    = S_SETUP;
                    idx_d      = 2'd0;
                    cnt_d      = '0;
                    dac_addr_d = 2'd0;
                    dac_data_d = ch_q[0];
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(T_SU - 1)) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                    wr_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == CW'(T_WR - 1)) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(T_HOLD - 1)) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d  = S_LOAD;
                        ldac_n_d = 1'b0;
                    end else begin
                        state_d    = S_SETUP;
                        idx_d      = idx_q + 2'd1;
                        dac_addr_d = idx_q + 2'd1;
                        dac_data_d = buf_q[idx_q + 2'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                if (cnt_q == CW'(T_LD - 1)) begin
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign d_out      = d_out_q;
    assign dac_data   = dac_data_q;
    assign dac_addr   = dac_addr_q;
    assign dac_wr_n   = wr_n_q;
    assign dac_ldac_n = ldac_n_q;

endmodule

// File: tb/tb_peripheral_dac_seq.sv
// Scoreboard bench for peripheral_dac_seq: directed scenarios plus randomized bus traffic.
module tb_peripheral_dac_seq;

    localparam int unsigned DW      = 8;
    localparam int unsigned T_SU    = 2;
    localparam int unsigned T_WR    = 4;
    localparam int unsigned T_HOLD  = 2;
    localparam int unsigned T_LD    = 4;
    localparam int unsigned SEQ_LEN = 4 * (T_SU + T_WR + T_HOLD) + T_LD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   d_in = '0;
    logic          cs = 1'b0;
    logic [3:0]    addr = '0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [15:0]   d_out;
    logic [DW-1:0] dac_data;
    logic [1:0]    dac_addr;
    logic          dac_wr_n;
    logic          dac_ldac_n;

    peripheral_dac_seq dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .cs         (cs),
        .addr       (addr),
        .rd         (rd),
        .wr         (wr),
        .d_out      (d_out),
        .dac_data   (dac_data),
        .dac_addr   (dac_addr),
        .dac_wr_n   (dac_wr_n),
        .dac_ldac_n (dac_ldac_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: expected read data, expected channel writes {addr,data}, pending loads
    logic [15:0] exp_rd [$];
    logic [9:0]  exp_dac [$];
    int          loads_pending = 0;

    // Reference model state
    logic [7:0]  ch_m [4];
    bit          started = 0;
    int          start_c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // busy is high for SEQ_LEN samples strictly after the start edge
    function automatic bit m_busy(input int sc);
        return started && (sc > start_c) && (sc <= start_c + int'(SEQ_LEN));
    endfunction

    function automatic bit m_done(input int sc);
        return started && (sc > start_c + int'(SEQ_LEN));
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] a, input int sc);
        case (a)
            4'h0, 4'h2, 4'h4, 4'h6: return {8'h00, ch_m[a[2:1]]};
            4'h8:                   return {14'b0, m_done(sc), m_busy(sc)};
            default:                return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [15:0] d, input int sc);
        case (a)
            4'h0, 4'h2, 4'h4, 4'h6: ch_m[a[2:1]] = d[7:0];
            4'hA: begin
                if (d[0] && !m_busy(sc)) begin
                    started = 1;
                    start_c = sc;
                    for (int i = 0; i < 4; i++) exp_dac.push_back({2'(i), ch_m[i]});
                    loads_pending++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ch_m[i] = 8'h00;
        started = 0;
        exp_dac.delete();
        exp_rd.delete();
        loads_pending = 0;
    endtask

    // One bus cycle; called at posedge+1, returns at the next posedge+1
    task automatic op(input bit c, input bit r, input bit w, input logic [3:0] a, input logic [15:0] d);
        int sc;
        sc = cyc + 1;
        if (c && r && !w) exp_rd.push_back(model_read(a, sc));
        if (c && w && !r) model_write(a, d, sc);
        cs = c; rd = r; wr = w; addr = a; d_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        op(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd_reg(input logic [3:0] a);
        op(1'b1, 1'b1, 1'b0, a, 16'h0000);
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
    endtask

    task automatic poll_status(input int n);
        repeat (n) rd_reg(4'h8);
    endtask

    // Monitor: read data, DAC write pulses, setup/hold, LDAC pulses, strobe overlap
    initial begin
        bit         rd_pend;
        logic       prev_wr_n, prev_ld_n;
        int         low_cnt, ld_cnt, stable_cnt, hold_left;
        logic [9:0] cur, prev_ad, pulse_ad;
        rd_pend = 0; prev_wr_n = 1; prev_ld_n = 1;
        low_cnt = 0; ld_cnt = 0; stable_cnt = 0; hold_left = 0;
        prev_ad = '0; pulse_ad = '0;
        forever begin
            @(negedge clk);
            cur = {dac_addr, dac_data};
            if (!rst) begin
                rd_pend = 0; prev_wr_n = 1; prev_ld_n = 1;
                low_cnt = 0; ld_cnt = 0; stable_cnt = 0; hold_left = 0;
                prev_ad = cur;
            end else begin
                if (rd_pend) begin
                    if (exp_rd.size() == 0) chk("read_unexpected", 32'(d_out), 32'hDEAD_0000);
                    else chk("read_data", 32'(d_out), 32'(exp_rd.pop_front()));
                end else begin
                    chk("d_out_idle", 32'(d_out), 32'h0);
                end
                rd_pend = cs & rd & ~wr;

                chk("strobe_overlap", 32'(dac_wr_n | dac_ldac_n), 32'h1);

                stable_cnt = (cur == prev_ad) ? stable_cnt + 1 : 1;

                if (!dac_wr_n) begin
                    if (prev_wr_n) begin
                        if (exp_dac.size() == 0) chk("dac_write_unexpected", 32'(cur), 32'hDEAD_0000);
                        else chk("dac_write_addr_data", 32'(cur), 32'(exp_dac.pop_front()));
                        chk("dac_setup_ok", 32'(stable_cnt >= int'(T_SU) + 1), 32'h1);
                        pulse_ad = cur;
                        low_cnt  = 1;
                    end else begin
                        low_cnt++;
                        chk("dac_stable_during_wr", 32'(cur), 32'(pulse_ad));
                    end
                end else if (!prev_wr_n) begin
                    chk("dac_wr_width", 32'(low_cnt), 32'(T_WR));
                    hold_left = int'(T_HOLD);
                end
                if (dac_wr_n && hold_left > 0) begin
                    chk("dac_hold", 32'(cur), 32'(pulse_ad));
                    hold_left--;
                end

                if (!dac_ldac_n) begin
                    if (prev_ld_n) begin
                        chk("ldac_after_all_ch", 32'(exp_dac.size()), 32'h0);
                        chk("ldac_expected", 32'(loads_pending > 0), 32'h1);
                        ld_cnt = 1;
                    end else begin
                        ld_cnt++;
                    end
                end else if (!prev_ld_n) begin
                    chk("ldac_width", 32'(ld_cnt), 32'(T_LD));
                    if (loads_pending > 0) loads_pending--;
                end

                prev_wr_n = dac_wr_n;
                prev_ld_n = dac_ldac_n;
                prev_ad   = cur;
            end
        end
    end

    // Hang guard
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Stimulus
    initial begin
        logic [3:0] addrs [8];
        int         kind;
        logic [3:0] a;
        logic [15:0] d;
        addrs[0] = 4'h0; addrs[1] = 4'h2; addrs[2] = 4'h4; addrs[3] = 4'h6;
        addrs[4] = 4'h8; addrs[5] = 4'hA; addrs[6] = 4'hC; addrs[7] = 4'hF;
        model_reset();

        // Power-on reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_n", 32'(dac_wr_n), 32'h1);
        chk("reset_ldac_n", 32'(dac_ldac_n), 32'h1);
        chk("reset_d_out", 32'(d_out), 32'h0);
        chk("reset_dac_addr_data", 32'({dac_addr, dac_data}), 32'h0);
        rst = 1'b1;
        idle(2);
        rd_reg(4'h8);
        for (int i = 0; i < 4; i++) rd_reg(4'(2 * i));

        // Channel write/read-back
        wr_reg(4'h0, 16'h0011);
        wr_reg(4'h2, 16'h0022);
        wr_reg(4'h4, 16'h0033);
        wr_reg(4'h6, 16'h0044);
        for (int i = 0; i < 4; i++) rd_reg(4'(2 * i));

        // Full sequence, status polled every cycle
        wr_reg(4'hA, 16'h0001);
        poll_status(int'(SEQ_LEN) + 4);

        // Channel write and re-start during a run must not disturb it
        wr_reg(4'hA, 16'h0001);
        idle(2);
        wr_reg(4'h2, 16'h00AA);
        wr_reg(4'hA, 16'h0001);
        rd_reg(4'h2);
        poll_status(int'(SEQ_LEN));
        wr_reg(4'hA, 16'h0001);
        poll_status(int'(SEQ_LEN) + 4);

        // Wide write truncation, unmapped address, rd&wr together
        wr_reg(4'h4, 16'hFFFF);
        rd_reg(4'h4);
        wr_reg(4'hA, 16'h0001);
        poll_status(int'(SEQ_LEN) + 2);
        wr_reg(4'hC, 16'h1234);
        rd_reg(4'hC);
        op(1'b1, 1'b1, 1'b1, 4'h0, 16'h5555);
        rd_reg(4'h0);
        wr_reg(4'hA, 16'h0000);
        rd_reg(4'h8);

        // Randomized bus traffic
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            a    = addrs[$urandom_range(0, 7)];
            d    = 16'($urandom);
            case (kind)
                0, 1, 2: wr_reg(a, d);
                3, 4, 5: rd_reg(a);
                6:       op(1'b1, 1'b1, 1'b1, a, d);
                7:       op(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
                default: wr_reg(4'hA, {d[15:1], 1'b1});
            endcase
        end
        poll_status(int'(SEQ_LEN) + 4);

        // Reset in the middle of the first channel's write strobe
        wr_reg(4'h0, 16'h005A);
        wr_reg(4'hA, 16'h0001);
        idle(int'(T_SU) + 1);
        chk("midrun_wr_n_low", 32'(dac_wr_n), 32'h0);
        rst = 1'b0;
        #1;
        chk("midrun_reset_wr_n", 32'(dac_wr_n), 32'h1);
        chk("midrun_reset_ldac_n", 32'(dac_ldac_n), 32'h1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd_reg(4'h8);
        for (int i = 0; i < 4; i++) rd_reg(4'(2 * i));
        idle(4);

        chk("read_queue_drained", 32'(exp_rd.size()), 32'h0);
        chk("dac_queue_drained", 32'(exp_dac.size()), 32'h0);
        chk("loads_drained", 32'(loads_pending), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
